// File: rtl/dmem_if.sv
// Data-side SRAM bus between EX (master) and the memory responder (slave).
interface dmem_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata, stallreq
  );
  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata, stallreq
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-port data SRAM with byte-lane writes and LAT-cycle reads; the read
// latency is hidden from the pipeline by holding the load in EX via stallreq.
module dmem_responder #(
  parameter int ADDR_W = 12,
  parameter int LAT    = 1
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  sram_io
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [1:0] CNT_LAST = (LAT >= 3) ? 2'(LAT - 2) : 2'd0;

  logic [31:0]       mem [2**ADDR_W];
  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [31:0]       rdata_q;

  logic [ADDR_W-1:0] widx;
  logic              accept, rd_req, wr_acc, rd_now;
  logic              unused_addr_bits;

  assign widx   = sram_io.data_sram_addr[ADDR_W+1:2];
  assign rd_req = sram_io.data_sram_en && (sram_io.data_sram_wen == 4'h0);
  assign accept = (state_q == IDLE) && sram_io.data_sram_en;
  assign wr_acc = accept && (sram_io.data_sram_wen != 4'h0);
  assign rd_now = accept && rd_req && (LAT == 1);
  assign unused_addr_bits = ^{sram_io.data_sram_addr[31:ADDR_W+2],
                              sram_io.data_sram_addr[1:0]};

  // Array is never reset; writes are simply suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      for (int i = 0; i < 4; i++)
        if (sram_io.data_sram_wen[i])
          mem[widx][8*i +: 8] <= sram_io.data_sram_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      raddr_q <= '0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      raddr_q <= raddr_d;
      if (rd_now)
        rdata_q <= mem[widx];
      else if (state_q == DONE)
        rdata_q <= mem[raddr_q];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    raddr_d = raddr_q;
    unique case (state_q)
      IDLE: begin
        if (accept && rd_req && LAT > 1) begin
          raddr_d = widx;
          if (LAT == 2) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            cnt_d   = 2'd1;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Rises in the accept cycle so EX freezes without a bubble.
  assign sram_io.stallreq = !rst &&
    (((state_q == IDLE) && rd_req && (LAT > 1)) || (state_q == BUSY));
  assign sram_io.data_sram_rdata = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: four responders (LAT 1/3/4 and a 4-bit wrap case) share one request bus.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        r1 = 1'b1, r3 = 1'b1, rw = 1'b1, r4 = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  wen = 4'h0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  int          n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  dmem_if b1 ();
  dmem_if b3 ();
  dmem_if bw ();
  dmem_if b4 ();

  assign b1.data_sram_en = en; assign b1.data_sram_wen = wen;
  assign b1.data_sram_addr = addr; assign b1.data_sram_wdata = wdata;
  assign b3.data_sram_en = en; assign b3.data_sram_wen = wen;
  assign b3.data_sram_addr = addr; assign b3.data_sram_wdata = wdata;
  assign bw.data_sram_en = en; assign bw.data_sram_wen = wen;
  assign bw.data_sram_addr = addr; assign bw.data_sram_wdata = wdata;
  assign b4.data_sram_en = en; assign b4.data_sram_wen = wen;
  assign b4.data_sram_addr = addr; assign b4.data_sram_wdata = wdata;

  dmem_responder #(.ADDR_W(12), .LAT(1)) u1 (.clk(clk), .rst(r1), .sram_io(b1));
  dmem_responder #(.ADDR_W(12), .LAT(3)) u3 (.clk(clk), .rst(r3), .sram_io(b3));
  dmem_responder #(.ADDR_W(4),  .LAT(1)) uw (.clk(clk), .rst(rw), .sram_io(bw));
  dmem_responder #(.ADDR_W(12), .LAT(4)) u4 (.clk(clk), .rst(r4), .sram_io(b4));

  // One cycle: drive request 1ns after the edge, return 4ns in (before negedge).
  task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d);
    @(posedge clk); #1;
    en = e; wen = w; addr = a; wdata = d;
    #3;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_reset;
    step(1'b1, 4'h0, 32'h0, 32'h0);
    n_cmp++; if (b3.stallreq !== 1'b0) begin n_fail++; $display("FAIL rst_stall3 got %b want 0", b3.stallreq); end
    n_cmp++; if (b4.stallreq !== 1'b0) begin n_fail++; $display("FAIL rst_stall4 got %b want 0", b4.stallreq); end
    step(1'b0, 4'h0, 32'h0, 32'h0);
    n_cmp++; if (b1.data_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata1 got %h want 0", b1.data_sram_rdata); end
    n_cmp++; if (b4.data_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata4 got %h want 0", b4.data_sram_rdata); end
    r1 = 1'b0; r3 = 1'b0; rw = 1'b0; r4 = 1'b0;
    idle(2);
  endtask

  task automatic test_write_read;
    step(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    n_cmp++; if (b1.stallreq !== 1'b0) begin n_fail++; $display("FAIL wr_stall got %b want 0", b1.stallreq); end
    step(1'b1, 4'h0, 32'h10, 32'h0);
    n_cmp++; if (b1.stallreq !== 1'b0) begin n_fail++; $display("FAIL rd_stall1 got %b want 0", b1.stallreq); end
    step(1'b0, 4'h0, 32'h0, 32'h0);
    n_cmp++; if (b1.data_sram_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd got %h want deadbeef", b1.data_sram_rdata); end
    idle(5);
  endtask

  task automatic test_byte_lanes;
    step(1'b1, 4'hF, 32'h20, 32'h11223344);
    step(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD);
    step(1'b1, 4'h0, 32'h20, 32'h0);
    step(1'b0, 4'h0, 32'h0, 32'h0);
    n_cmp++; if (b1.data_sram_rdata !== 32'h11BB33DD) begin n_fail++; $display("FAIL byte_lanes got %h want 11bb33dd", b1.data_sram_rdata); end
    idle(5);
  endtask

  task automatic test_back_to_back;
    step(1'b1, 4'hF, 32'h0, 32'hA0A0A0A0);
    step(1'b1, 4'hF, 32'h4, 32'hA1A1A1A1);
    step(1'b1, 4'hF, 32'h8, 32'hA2A2A2A2);
    step(1'b1, 4'h0, 32'h0, 32'h0);
    step(1'b1, 4'h0, 32'h4, 32'h0);
    n_cmp++; if (b1.data_sram_rdata !== 32'hA0A0A0A0) begin n_fail++; $display("FAIL b2b_0 got %h want a0a0a0a0", b1.data_sram_rdata); end
    n_cmp++; if (b1.stallreq !== 1'b0) begin n_fail++; $display("FAIL b2b_stall got %b want 0", b1.stallreq); end
    step(1'b1, 4'h0, 32'h8, 32'h0);
    n_cmp++; if (b1.data_sram_rdata !== 32'hA1A1A1A1) begin n_fail++; $display("FAIL b2b_1 got %h want a1a1a1a1", b1.data_sram_rdata); end
    step(1'b0, 4'h0, 32'h4, 32'h0);
    n_cmp++; if (b1.data_sram_rdata !== 32'hA2A2A2A2) begin n_fail++; $display("FAIL b2b_2 got %h want a2a2a2a2", b1.data_sram_rdata); end
    step(1'b0, 4'h0, 32'h0, 32'h0);
    n_cmp++; if (b1.data_sram_rdata !== 32'hA2A2A2A2) begin n_fail++; $display("FAIL b2b_hold got %h want a2a2a2a2", b1.data_sram_rdata); end
    idle(5);
  endtask

  task automatic test_wrap;
    step(1'b1, 4'hF, 32'h40, 32'h5);
    step(1'b1, 4'hF, 32'h3C, 32'h77);
    step(1'b1, 4'h0, 32'h00, 32'h0);
    step(1'b1, 4'h0, 32'h7F, 32'h0);
    n_cmp++; if (bw.data_sram_rdata !== 32'h5) begin n_fail++; $display("FAIL wrap_lo got %h want 5", bw.data_sram_rdata); end
    step(1'b0, 4'h0, 32'h0, 32'h0);
    n_cmp++; if (bw.data_sram_rdata !== 32'h77) begin n_fail++; $display("FAIL wrap_hi got %h want 77", bw.data_sram_rdata); end
    idle(5);
  endtask

  task automatic test_latency3;
    step(1'b1, 4'hF, 32'h30, 32'hCAFE0003);
    n_cmp++; if (b3.stallreq !== 1'b0) begin n_fail++; $display("FAIL l3_wr_stall got %b want 0", b3.stallreq); end
    step(1'b1, 4'hF, 32'h34, 32'h12345678);
    step(1'b1, 4'h0, 32'h30, 32'h0);
    n_cmp++; if (b3.stallreq !== 1'b1) begin n_fail++; $display("FAIL l3_stall_t got %b want 1", b3.stallreq); end
    step(1'b1, 4'h0, 32'h30, 32'h0);
    n_cmp++; if (b3.stallreq !== 1'b1) begin n_fail++; $display("FAIL l3_stall_t1 got %b want 1", b3.stallreq); end
    step(1'b1, 4'h0, 32'h30, 32'h0);
    n_cmp++; if (b3.stallreq !== 1'b0) begin n_fail++; $display("FAIL l3_stall_t2 got %b want 0", b3.stallreq); end
    step(1'b1, 4'h0, 32'h34, 32'h0);
    n_cmp++; if (b3.data_sram_rdata !== 32'hCAFE0003) begin n_fail++; $display("FAIL l3_data got %h want cafe0003", b3.data_sram_rdata); end
    n_cmp++; if (b3.stallreq !== 1'b1) begin n_fail++; $display("FAIL l3_reaccept got %b want 1", b3.stallreq); end
    step(1'b1, 4'h0, 32'h34, 32'h0);
    n_cmp++; if (b3.stallreq !== 1'b1) begin n_fail++; $display("FAIL l3_stall2_t1 got %b want 1", b3.stallreq); end
    step(1'b1, 4'h0, 32'h34, 32'h0);
    n_cmp++; if (b3.stallreq !== 1'b0) begin n_fail++; $display("FAIL l3_stall2_t2 got %b want 0", b3.stallreq); end
    n_cmp++; if (b3.data_sram_rdata !== 32'hCAFE0003) begin n_fail++; $display("FAIL l3_data_hold got %h want cafe0003", b3.data_sram_rdata); end
    step(1'b0, 4'h0, 32'h0, 32'h0);
    n_cmp++; if (b3.data_sram_rdata !== 32'h12345678) begin n_fail++; $display("FAIL l3_data2 got %h want 12345678", b3.data_sram_rdata); end
    idle(5);
  endtask

  task automatic test_reset_busy;
    step(1'b1, 4'hF, 32'h50, 32'h0BADF00D);
    step(1'b1, 4'hF, 32'h54, 32'h600DF00D);
    step(1'b1, 4'h0, 32'h54, 32'h0);
    repeat (3) step(1'b1, 4'h0, 32'h54, 32'h0);
    step(1'b0, 4'h0, 32'h0, 32'h0);
    n_cmp++; if (b4.data_sram_rdata !== 32'h600DF00D) begin n_fail++; $display("FAIL l4_data got %h want 600df00d", b4.data_sram_rdata); end
    idle(1);
    step(1'b1, 4'h0, 32'h50, 32'h0);
    n_cmp++; if (b4.stallreq !== 1'b1) begin n_fail++; $display("FAIL l4_stall_t got %b want 1", b4.stallreq); end
    step(1'b1, 4'h0, 32'h50, 32'h0);
    r4 = 1'b1;
    #0;
    n_cmp++; if (b4.stallreq !== 1'b0) begin n_fail++; $display("FAIL rb_stall_rst got %b want 0", b4.stallreq); end
    step(1'b0, 4'h0, 32'h0, 32'h0);
    r4 = 1'b0;
    n_cmp++; if (b4.stallreq !== 1'b0) begin n_fail++; $display("FAIL rb_stall got %b want 0", b4.stallreq); end
    n_cmp++; if (b4.data_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL rb_rdata got %h want 0", b4.data_sram_rdata); end
    step(1'b1, 4'h0, 32'h50, 32'h0);
    n_cmp++; if (b4.stallreq !== 1'b1) begin n_fail++; $display("FAIL rb_fresh_stall got %b want 1", b4.stallreq); end
    repeat (2) step(1'b1, 4'h0, 32'h50, 32'h0);
    step(1'b1, 4'h0, 32'h50, 32'h0);
    n_cmp++; if (b4.stallreq !== 1'b0) begin n_fail++; $display("FAIL rb_release got %b want 0", b4.stallreq); end
    n_cmp++; if (b4.data_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL rb_discard got %h want 0", b4.data_sram_rdata); end
    step(1'b0, 4'h0, 32'h0, 32'h0);
    n_cmp++; if (b4.data_sram_rdata !== 32'h0BADF00D) begin n_fail++; $display("FAIL rb_fresh_data got %h want 0badf00d", b4.data_sram_rdata); end
    idle(3);
  endtask

  initial begin
    idle(1);
    test_reset;
    test_write_read;
    test_byte_lanes;
    test_back_to_back;
    test_wrap;
    test_latency3;
    test_reset_busy;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-side SRAM responder for the five-stage CPU. It is the memory end of the `data_sram_*` interface: EX issues `en`/`wen`/`addr`/`wdata`, and this block performs byte-lane writes and returns `data_sram_rdata`. MEM consumes that read data in the cycle after the load leaves EX. A configurable read latency is covered by raising `stallreq` toward the stall controller, so a load is held in EX until its data will be valid in MEM.

## Interface
- `ADDR_W`, 12, word-address bits. Array depth is 2^ADDR_W words of 32 bits.
- `LAT`, 1, read latency in cycles. Legal range is 1..4.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `data_sram_en` input 1: request valid this cycle.
- `data_sram_wen` input 4: byte write enables. Nonzero means write, zero means read.
- `data_sram_addr` input 32: byte address. Word index is `addr[ADDR_W+1:2]`. `addr[1:0]` and bits above `ADDR_W+1` are ignored, so addresses wrap.
- `data_sram_wdata` input 32: write data. Byte i is on bits `[8i+7:8i]`.
- `data_sram_rdata` output 32: registered read data.
- `stallreq` output 1: stall request to the stall controller. Combinational.

## Operation
- **States:** IDLE, BUSY, DONE, plus a 2-bit counter `cnt`. The address is latched into `raddr_r` when a read is accepted.
- **Accept:** a request is accepted only in IDLE with `en`=1. Inputs seen in BUSY and DONE are the held copy of the same request and are ignored.
- **Write accept:**
  - Lanes with `wen[i]`=1 are written at the clock edge ending the accept cycle.
  - Lanes with `wen[i]`=0 are unchanged.
  - Writes are posted: no stall, state stays IDLE, `rdata` unchanged.
- **Read accept, `LAT`=1:** the word is registered into `rdata` at the edge ending the accept cycle. State stays IDLE, so back-to-back reads are accepted every cycle.
- **Read accept, `LAT`>=2:**
  - Latch `raddr_r`.
  - `LAT`=2: go to DONE.
  - `LAT`>=3: go to BUSY with `cnt`=1.
- **BUSY:** increment `cnt` each cycle. Go to DONE when `cnt`=`LAT`-2.
- **DONE:** load `rdata` from `mem[raddr_r]` at the edge ending the cycle, then return to IDLE.
- **`stallreq`:** equals (IDLE & `en` & `wen`==0 & `LAT`>1) | BUSY. It is 0 in DONE and 0 whenever `rst`=1.
- **`en`=0 in IDLE:** no action. `rdata` holds its last value.
- **Read after write:** a read of a word written in the previous cycle returns the new data. The array has a single port, so same-cycle conflicts cannot occur.
- **Reset:**
  - State goes to IDLE, `cnt`=0, `raddr_r`=0, `rdata`=32'h0, `stallreq`=0.
  - Array contents are not reset.
  - A reset during BUSY or DONE discards the pending read; `rdata` stays 0.

## Timing
- **Read latency:** a read accepted in cycle t has `rdata` valid from cycle t+`LAT` until the edge ending the next read's data cycle.
- **Stall window:** `stallreq` is high in cycles t..t+`LAT`-2, i.e. `LAT`-1 cycles, zero for `LAT`=1. It rises combinationally in cycle t, so the stall controller freezes EX in the same cycle.
- **Release:** in cycle t+`LAT`-1 `stallreq` is low, EX advances at that edge, and the load reaches MEM in cycle t+`LAT` together with valid `rdata`.
- **Write visibility:** a write accepted in cycle t is visible to any read accepted in cycle t+1 or later.
- **Throughput:**
  - Writes: one per cycle.
  - Reads: one per `LAT` cycles. The next accept is possible in cycle t+`LAT`.

## Test plan
- **Write then read, `LAT`=1:** write 32'hDEADBEEF to 0x10 with `wen`=4'hF at cycle 0, read 0x10 at cycle 1 -> `rdata`=32'hDEADBEEF in cycle 2, `stallreq` always 0.
- **Byte lanes:** preload 0x20 = 32'h11223344, then write 32'hAABBCCDD with `wen`=4'b0101, then read -> 32'h11BB33DD.
- **Latency `LAT`=3:** read accepted at cycle 5, held for 2 cycles -> `stallreq`=1 in cycles 5-6 and 0 in cycle 7, `rdata` correct in cycle 8, the held request is not re-accepted, and a new read at cycle 8 is accepted.
- **Wrap, `ADDR_W`=4:** write 32'h5 to 0x40, read 0x00 -> 32'h5.
- **Reset during BUSY, `LAT`=4:** assert `rst` in cycle t+1 -> `stallreq`=0 and `rdata`=0 from cycle t+2, state IDLE, a fresh read afterwards returns correct data at +4.
- **Back-to-back reads, `LAT`=1:** read 0x0, 0x4, 0x8 in consecutive cycles -> `rdata` gives the three words on consecutive cycles with no stall. `en`=0 afterwards -> `rdata` holds the last word.
